// File: rtl/uart_tx_fifo_drain_if.sv
// uart_tx_fifo_drain_if: FIFO read port, baud control and serial/status bundle for the UART drain.
//   i_enable, i_baud_div, i_fifo_empty, i_fifo_rddata : into the drain
//   o_fifo_rden, o_txd, o_busy, o_frame_done          : out of the drain
//   slave  = the drain itself; master = the FIFO/CPU/pad side
interface uart_tx_fifo_drain_if #(
  parameter int P_WIDTH = 8,
  parameter int P_DIV_W = 16
);
  logic               i_enable;
  logic [P_DIV_W-1:0] i_baud_div;
  logic               i_fifo_empty;
  logic [P_WIDTH-1:0] i_fifo_rddata;
  logic               o_fifo_rden;
  logic               o_txd;
  logic               o_busy;
  logic               o_frame_done;
  modport master (
    output i_enable, i_baud_div, i_fifo_empty, i_fifo_rddata,
    input  o_fifo_rden, o_txd, o_busy, o_frame_done
  );
  modport slave (
    input  i_enable, i_baud_div, i_fifo_empty, i_fifo_rddata,
    output o_fifo_rden, o_txd, o_busy, o_frame_done
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops bytes from the TX FIFO and serialises them as UART frames.
//   i_clk, i_rst (async, active-high) : clock and reset
//   bus (uart_tx_fifo_drain_if.slave) : enable, baud divisor, FIFO read port, TXD, busy, frame_done
//   Optional macro UART_TX_PARITY_EN adds an even-parity bit between data and stop.
module uart_tx_fifo_drain #(
  parameter int P_WIDTH     = 8,
  parameter int P_DIV_W     = 16,
  parameter int P_STOP_BITS = 1
) (
  input logic                 i_clk,
  input logic                 i_rst,
  uart_tx_fifo_drain_if.slave bus
);
  localparam int BW = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(P_WIDTH - 1);
  localparam logic LAST_STOP = (P_STOP_BITS == 2);
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state_q, state_d;
  logic [P_DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic stop_q, stop_d;
  logic [P_WIDTH-1:0] shift_q, shift_d;
  logic txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  logic bit_end, timing;
  assign bit_end = cnt_q == div_q;
  // Only the serial states pace themselves with the bit counter.
  assign timing = !(state_q inside {IDLE, FETCH, LOAD});
  assign bus.o_fifo_rden = state_q == FETCH;
  assign bus.o_busy = state_q != IDLE;
  assign bus.o_txd = txd_q;
  assign bus.o_frame_done = state_q == STOP && bit_end && stop_q == LAST_STOP;
  always_comb begin
    state_d = state_q;
    cnt_d = timing && !bit_end ? cnt_q + 1'b1 : '0;
    div_d = div_q;
    bit_d = bit_q;
    stop_d = stop_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
`endif
    case (state_q)
      IDLE: state_d = bus.i_enable && !bus.i_fifo_empty ? FETCH : IDLE;
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d = bus.i_fifo_rddata;
        div_d = bus.i_baud_div;
`ifdef UART_TX_PARITY_EN
        par_d = ^bus.i_fifo_rddata;
`endif
        state_d = START;
      end
      START: if (bit_end) begin
        bit_d = '0;
        state_d = DATA;
      end
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 1'b1;
        if (bit_q == LAST_BIT) begin
          stop_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        stop_d = 1'b0;
        state_d = STOP;
      end
`endif
      STOP: if (bit_end) begin
        stop_d = stop_q != LAST_STOP;
        state_d = stop_q == LAST_STOP ? IDLE : STOP;
      end
      default: state_d = IDLE;
    endcase
    // TXD is registered from the next state so the pin changes with the state.
`ifdef UART_TX_PARITY_EN
    txd_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
`else
    txd_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`endif
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= '0;
      bit_q <= '0;
      stop_q <= 1'b0;
      shift_q <= '0;
      txd_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      bit_q <= bit_d;
      stop_q <= stop_d;
      shift_q <= shift_d;
      txd_q <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: scoreboard bench with a FIFO model and an independent serial decoder.
module tb_uart_tx_fifo_drain;
  localparam int W = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FB = 2 + W + PB;
  typedef struct {logic [7:0] data; int period;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  logic [7:0] mem[$];
  int gaps[$];
  int rd_ptr = 0, n_chk = 0, n_fail = 0, cyc = 0, frames = 0, rden_cnt = 0;
  int spur_fifo = 0, spur_fd = 0, start_cyc = 0, done_cyc = 0;
  logic rden_prev = 1'b0;
  uart_tx_fifo_drain_if #(.P_WIDTH(W), .P_DIV_W(16)) bus ();
  uart_tx_fifo_drain #(.P_WIDTH(W), .P_DIV_W(16), .P_STOP_BITS(1)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input int per);
    mem.push_back(d);
    sb.push_back('{d, per});
  endtask
  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_timeout", frames >= target, 1);
    repeat (2) @(negedge clk);
  endtask
  // FIFO model: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    cyc++;
    if (bus.o_fifo_rden === 1'b1) begin
      if (bus.i_fifo_empty !== 1'b0 || rden_prev) spur_fifo++;
      rden_cnt++;
      bus.i_fifo_rddata <= rd_ptr < mem.size() ? mem[rd_ptr] : 8'hxx;
      rd_ptr++;
    end
    rden_prev <= bus.o_fifo_rden;
  end
  always @(negedge clk) begin
    #1;
    bus.i_fifo_empty = rd_ptr >= mem.size();
  end
  // Serial decoder: finds a start edge, samples every clock of the frame.
  initial begin : monitor
    exp_t e;
    int p, total, unst, fdb;
    bit ab;
    logic prev;
    logic [FB-1:0] bits;
    logic [7:0] got;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
        continue;
      end
      if (prev && bus.o_txd === 1'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_start", sb.size(), 1);
          e = '{8'h00, 1};
        end else e = sb.pop_front();
        p = e.period;
        total = FB * p;
        start_cyc = cyc;
        gaps.push_back(start_cyc - done_cyc);
        ab = 0;
        unst = 0;
        fdb = 0;
        bits = '0;
        for (int c = 0; c < total; c++) begin
          if (c > 0) @(negedge clk);
          if (rst) begin
            ab = 1;
            break;
          end
          if (c % p == 0) bits[c / p] = bus.o_txd;
          else if (bus.o_txd !== bits[c / p]) unst++;
          if (bus.o_frame_done !== (c == total - 1)) fdb++;
        end
        if (!ab) begin
          for (int i = 0; i < W; i++) got[i] = bits[1 + i];
          chk("start_bit", bits[0], 0);
          chk("stop_bit", bits[FB-1], 1);
          chk("data_byte", got, e.data);
          chk("bit_stable", unst, 0);
          chk("frame_done_pos", fdb, 0);
`ifdef UART_TX_PARITY_EN
          chk("parity_bit", bits[1 + W], ^e.data);
`endif
          done_cyc = cyc;
          frames++;
        end
        prev = 1'b1;
      end else begin
        prev = bus.o_txd;
        if (bus.o_frame_done === 1'b1) spur_fd++;
      end
    end
  end
  initial begin : stim
    int bad, r0, f0, c0;
    bus.i_enable = 1'b1;
    bus.i_baud_div = 16'd3;
    repeat (3) @(negedge clk);
    chk("rst_txd", bus.o_txd, 1);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_rden", bus.o_fifo_rden, 0);
    chk("rst_done", bus.o_frame_done, 0);
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.o_txd !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_fifo_rden !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);
    chk("idle_rden_cnt", rden_cnt, 0);
    r0 = rden_cnt; f0 = frames; c0 = cyc;
    send(8'hA5, 4);
    wait_frames(f0 + 1, 200);
    chk("single_rden", rden_cnt - r0, 1);
    chk("single_latency", start_cyc - c0, 3);
    bus.i_baud_div = 16'd0;
    r0 = rden_cnt; f0 = frames;
    send(8'h00, 1);
    send(8'hFF, 1);
    send(8'h55, 1);
    wait_frames(f0 + 3, 200);
    chk("b2b_rden", rden_cnt - r0, 3);
    chk("b2b_gap_a", gaps[gaps.size() - 2], 4);
    chk("b2b_gap_b", gaps[gaps.size() - 1], 4);
    bus.i_baud_div = 16'd3;
    r0 = rden_cnt; f0 = frames;
    send(8'h3C, 4);
    send(8'h99, 8);
    repeat (15) @(negedge clk);
    chk("mid_busy", bus.o_busy, 1);
    bus.i_enable = 1'b0;
    bus.i_baud_div = 16'd7;
    wait_frames(f0 + 1, 200);
    repeat (20) @(negedge clk);
    chk("hold_rden", rden_cnt - r0, 1);
    chk("hold_busy", bus.o_busy, 0);
    chk("hold_frames", frames - f0, 1);
    bus.i_enable = 1'b1;
    wait_frames(f0 + 2, 300);
    chk("resume_rden", rden_cnt - r0, 2);
    bus.i_baud_div = 16'd3;
    r0 = rden_cnt;
    send(8'hC3, 4);
    repeat (24) @(negedge clk);
    chk("pre_arst_busy", bus.o_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_txd", bus.o_txd, 1);
    chk("arst_busy", bus.o_busy, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    chk("arst_rden", rden_cnt - r0, 1);
    r0 = rden_cnt; f0 = frames;
    send(8'h5A, 4);
    wait_frames(f0 + 1, 200);
    chk("post_arst_rden", rden_cnt - r0, 1);
`ifdef UART_TX_PARITY_EN
    bus.i_baud_div = 16'd1;
    f0 = frames;
    send(8'h07, 2);
    send(8'h03, 2);
    wait_frames(f0 + 2, 200);
`endif
    repeat (5) @(negedge clk);
    chk("spurious_rden", spur_fifo, 0);
    chk("spurious_done", spur_fd, 0);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
